// File: rtl/filtro_biquad_pkg.sv
// Shared constants for the biquad filter: default widths, accumulator guard bits, FSM encoding.
package filtro_biquad_pkg;

  localparam int unsigned W_DEF     = 16;
  localparam int unsigned F_DEF     = 10;
  localparam int unsigned ACC_GUARD = 3;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StUpdate
  } state_t;

  function automatic int unsigned acc_width(int unsigned w);
    return 2 * w + ACC_GUARD;
  endfunction

endpackage

// File: rtl/unidad_mac.sv
// Signed multiply-accumulate: full-precision product added to or subtracted from the accumulator.
module unidad_mac #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 35
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 sub,
  input  logic signed [W-1:0]  coef,
  input  logic signed [W-1:0]  samp,
  output logic signed [AW-1:0] acc
);

  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext;

  assign prod     = coef * samp;
  assign prod_ext = {{(AW-2*W){prod[2*W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? acc - prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/filtro_biquad.sv
// Direct-form-I biquad, one product per cycle. Define FILTRO_SAT_EN to clamp the result
// instead of wrapping it to W bits.
module filtro_biquad
  import filtro_biquad_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned F = F_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] UK,
  output logic                ready,
  input  logic                flush,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  output logic signed [W-1:0] YK,
  output logic                out_valid,
  output logic                overrun
);

  localparam int unsigned AW = acc_width(W);
  localparam int unsigned SW = AW - F;
  localparam logic signed [AW-1:0] HALF = {{(AW-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXV = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t              state;
  logic [2:0]          step;
  logic signed [W-1:0] x0, x1, x2, y1, y2;
  logic signed [W-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;
  logic signed [W-1:0] op_coef, op_samp;
  logic                op_sub;
  logic                accept;
  logic signed [AW-1:0] acc, rnd;
  logic signed [SW-1:0] shifted;
  logic signed [W-1:0]  res;

  assign accept = (state == StIdle) && in_valid && !flush;

  // Operand order b0, b1, b2, a1, a2; feedback terms are subtracted.
  always_comb begin
    op_coef = '0;
    op_samp = '0;
    op_sub  = 1'b0;
    unique case (step)
      3'd0: begin op_coef = c_b0; op_samp = x0; end
      3'd1: begin op_coef = c_b1; op_samp = x1; end
      3'd2: begin op_coef = c_b2; op_samp = x2; end
      3'd3: begin op_coef = c_a1; op_samp = y1; op_sub = 1'b1; end
      3'd4: begin op_coef = c_a2; op_samp = y2; op_sub = 1'b1; end
      default: ;
    endcase
  end

  unidad_mac #(
    .W  (W),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (state == StMac),
    .sub   (op_sub),
    .coef  (op_coef),
    .samp  (op_samp),
    .acc   (acc)
  );

  // Round half-up, then drop the fractional bits.
  assign rnd     = acc + HALF;
  assign shifted = rnd[AW-1:F];

`ifdef FILTRO_SAT_EN
  always_comb begin
    if (shifted > MAXV) begin
      res = MAXV[W-1:0];
    end else if (shifted < MINV) begin
      res = MINV[W-1:0];
    end else begin
      res = shifted[W-1:0];
    end
  end
`else
  assign res = shifted[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      step      <= '0;
      ready     <= 1'b1;
      YK        <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      c_b0      <= '0;
      c_b1      <= '0;
      c_b2      <= '0;
      c_a1      <= '0;
      c_a2      <= '0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= in_valid && !ready;
      unique case (state)
        StIdle: begin
          if (flush) begin
            x1 <= '0;
            x2 <= '0;
            y1 <= '0;
            y2 <= '0;
          end else if (in_valid) begin
            x0    <= UK;
            c_b0  <= b0;
            c_b1  <= b1;
            c_b2  <= b2;
            c_a1  <= a1;
            c_a2  <= a2;
            step  <= '0;
            ready <= 1'b0;
            state <= StMac;
          end
        end
        StMac: begin
          step <= step + 3'd1;
          if (step == 3'd4) begin
            state <= StUpdate;
          end
        end
        StUpdate: begin
          YK        <= res;
          y1        <= res;
          y2        <= y1;
          x1        <= x0;
          x2        <= x1;
          out_valid <= 1'b1;
          ready     <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_biquad.sv
// Scoreboard bench for filtro_biquad (W=16, F=10); honours FILTRO_SAT_EN like the RTL.
module tb_filtro_biquad;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] UK;
  logic               ready;
  logic               flush;
  logic signed [15:0] b0, b1, b2, a1, a2;
  logic signed [15:0] YK;
  logic               out_valid;
  logic               overrun;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  longint exp_q[$];
  int     edge_q[$];
  longint mx1, mx2, my1, my2;
  longint last_y;

  filtro_biquad #(
    .W (16),
    .F (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .UK        (UK),
    .ready     (ready),
    .flush     (flush),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .a1        (a1),
    .a2        (a2),
    .YK        (YK),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input longint x, input longint c0, input longint c1,
                                   input longint c2, input longint c3, input longint c4);
    longint acc, r;
    logic signed [15:0] yv;
    acc = c0 * x + c1 * mx1 + c2 * mx2 - c3 * my1 - c4 * my2;
    r   = (acc + 512) >>> 10;
`ifdef FILTRO_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    yv  = r[15:0];
    mx2 = mx1;
    mx1 = x;
    my2 = my1;
    my1 = yv;
    return yv;
  endfunction

  function automatic void model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endfunction

  always @(posedge clk) begin : mon
    longint e;
    int n;
    edge_n++;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        n = edge_q.pop_front();
        check("yk", YK, e);
        check("latency", edge_n, n);
        check("ready_after_update", ready, 1);
        last_y = e;
      end
    end
  end

  task automatic send(input int x, input int c0, input int c1, input int c2, input int c3,
                      input int c4);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 100);
    if (!ready) check("ready_wait", 0, 1);
    in_valid = 1'b1;
    UK = 16'(x);
    b0 = 16'(c0); b1 = 16'(c1); b2 = 16'(c2); a1 = 16'(c3); a2 = 16'(c4);
    exp_q.push_back(model(x, c0, c1, c2, c3, c4));
    edge_q.push_back(edge_n + 7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ready_busy", ready, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      edge_q.delete();
    end
  endtask

  task automatic do_flush(input logic with_valid);
    @(negedge clk);
    flush = 1'b1;
    in_valid = with_valid;
    UK = 16'sd777;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check("flush_ready", ready, 1);
    check("flush_no_overrun", overrun, 0);
    check("flush_yk_held", YK, last_y);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; UK = '0;
    b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    model_clear();
    last_y = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_yk", YK, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ready", ready, 1);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;

    send(300, 1024, 0, 0, 0, 0);
    drain();

    do_flush(1'b0);
    send(1024, 0, 512, 0, 0, 0);
    send(0, 0, 512, 0, 0, 0);
    drain();

    do_flush(1'b0);
    send(1024, 1024, 0, 0, -512, 0);
    send(0, 1024, 0, 0, -512, 0);
    send(0, 1024, 0, 0, -512, 0);
    drain();

    do_flush(1'b0);
    send(32767, 2047, 0, 0, 0, 0);
    drain();

    // Sample offered mid-computation is dropped; coefficient change must not leak in.
    do_flush(1'b0);
    send(1000, 700, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    UK = 16'sd999;
    b0 = 16'sd3000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("overrun_pulse", overrun, 1);
    @(posedge clk);
    #1;
    check("overrun_clear", overrun, 0);
    drain();

    send(500, 1024, 300, 200, 100, 50);
    send(-700, 1024, 300, 200, 100, 50);
    drain();
    do_flush(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("flush_valid_ready", ready, 1);
    send(400, 1024, 512, 512, 512, 512);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 16384)) - 8192, int'($urandom_range(0, 2048)) - 1024,
           int'($urandom_range(0, 2048)) - 1024, int'($urandom_range(0, 2048)) - 1024,
           int'($urandom_range(0, 1024)) - 512, int'($urandom_range(0, 1024)) - 512);
    end
    drain();

    // Reset during a computation aborts it without an out_valid pulse.
    send(1234, 1024, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    edge_q.delete();
    @(posedge clk);
    #1;
    check("abort_yk", YK, 0);
    check("abort_ready", ready, 1);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    last_y = 0;
    repeat (10) @(posedge clk);
    #2;
    send(100, 1024, 0, 0, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
